// File: rtl/sram_arb_pkg.sv
// Shared widths, owner encoding and payload/lock types for sram_req_arbiter.
package sram_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned SIZE_W = 2;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] wdata;
  } sram_req_t;

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_INST = 2'd1,
    LOCK_DATA = 2'd2
  } lock_state_e;

  function automatic lock_state_e lock_of(input logic owner);
    return (owner == OWNER_DATA) ? LOCK_DATA : LOCK_INST;
  endfunction

endpackage

// File: rtl/sram_req_arbiter_owner_fifo.sv
// Owner FIFO: records which master owns each accepted transaction, in order.
module owner_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic push_i,
  input  logic owner_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Power-of-two depth: pointers wrap naturally.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) wr_d = wr_q + PTR_W'(1);
    if (do_pop)  rd_d = rd_q + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= owner_i;
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Two-master (inst/data) to one-slave SRAM-like bus arbiter with in-order response routing.
// Define SRAM_ARB_RR_EN for round-robin ties; default is fixed data-over-inst priority.
module sram_req_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              inst_sram_req,
  input  logic              inst_sram_wr,
  input  logic [SIZE_W-1:0] inst_sram_size,
  input  logic [ADDR_W-1:0] inst_sram_addr,
  input  logic [STRB_W-1:0] inst_sram_wstrb,
  input  logic [DATA_W-1:0] inst_sram_wdata,
  output logic              inst_sram_addr_ok,
  output logic              inst_sram_data_ok,
  output logic [DATA_W-1:0] inst_sram_rdata,

  input  logic              data_sram_req,
  input  logic              data_sram_wr,
  input  logic [SIZE_W-1:0] data_sram_size,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [STRB_W-1:0] data_sram_wstrb,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic              data_sram_addr_ok,
  output logic              data_sram_data_ok,
  output logic [DATA_W-1:0] data_sram_rdata,

  output logic              sram_req,
  output logic              sram_wr,
  output logic [SIZE_W-1:0] sram_size,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [STRB_W-1:0] sram_wstrb,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic              sram_addr_ok,
  input  logic              sram_data_ok,
  input  logic [DATA_W-1:0] sram_rdata
);

  sram_req_t   inst_fields;
  sram_req_t   data_fields;
  sram_req_t   win_fields;
  lock_state_e lock_q, lock_d;
  logic        win_valid;
  logic        win_owner;
  logic        tie_owner;
  logic        req_c;
  logic        accept;
  logic        resp_valid;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_head;

  assign inst_fields = '{wr: inst_sram_wr, size: inst_sram_size, addr: inst_sram_addr,
                         wstrb: inst_sram_wstrb, wdata: inst_sram_wdata};
  assign data_fields = '{wr: data_sram_wr, size: data_sram_size, addr: data_sram_addr,
                         wstrb: data_sram_wstrb, wdata: data_sram_wdata};

`ifdef SRAM_ARB_RR_EN
  logic last_owner_q, last_owner_d;

  assign last_owner_d = accept ? win_owner : last_owner_q;
  assign tie_owner    = ~last_owner_q;

  always_ff @(posedge clk) begin
    if (!resetn) last_owner_q <= OWNER_INST;
    else         last_owner_q <= last_owner_d;
  end
`else
  assign tie_owner = OWNER_DATA;
`endif

  // Lock FSM: a request left pending by the slave pins the grant to its master.
  always_ff @(posedge clk) begin
    if (!resetn) lock_q <= LOCK_NONE;
    else         lock_q <= lock_d;
  end

  always_comb begin
    lock_d    = lock_q;
    win_valid = 1'b0;
    win_owner = OWNER_INST;
    req_c     = 1'b0;
    case (lock_q)
      LOCK_INST: begin
        win_valid = 1'b1;
        win_owner = OWNER_INST;
      end
      LOCK_DATA: begin
        win_valid = 1'b1;
        win_owner = OWNER_DATA;
      end
      default: begin
        if (!fifo_full) begin
          win_valid = inst_sram_req | data_sram_req;
          if (inst_sram_req & data_sram_req) win_owner = tie_owner;
          else                               win_owner = data_sram_req ? OWNER_DATA : OWNER_INST;
        end
      end
    endcase
    req_c = win_valid & ~fifo_full & resetn;
    if (req_c) lock_d = sram_addr_ok ? LOCK_NONE : lock_of(win_owner);
  end

  assign accept     = req_c & sram_addr_ok;
  assign win_fields = !win_valid ? '0 : ((win_owner == OWNER_DATA) ? data_fields : inst_fields);

  assign sram_req   = req_c;
  assign sram_wr    = win_fields.wr;
  assign sram_size  = win_fields.size;
  assign sram_addr  = win_fields.addr;
  assign sram_wstrb = win_fields.wstrb;
  assign sram_wdata = win_fields.wdata;

  assign inst_sram_addr_ok = accept & (win_owner == OWNER_INST);
  assign data_sram_addr_ok = accept & (win_owner == OWNER_DATA);

  // A response with nothing outstanding is dropped rather than routed.
  assign resp_valid        = sram_data_ok & ~fifo_empty & resetn;
  assign inst_sram_data_ok = resp_valid & (fifo_head == OWNER_INST);
  assign data_sram_data_ok = resp_valid & (fifo_head == OWNER_DATA);
  assign inst_sram_rdata   = sram_rdata;
  assign data_sram_rdata   = sram_rdata;

  owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (accept),
    .owner_i (win_owner),
    .pop_i   (resp_valid),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

endmodule

// File: doc/sram_req_arbiter.md
# sram_req_arbiter

Two-master to one-slave arbiter for the SRAM-like bus. It shares a single memory port between the IF-stage instruction requester (master 0, `inst_`) and the MEM-stage data requester (master 1, `data_`). The block arbitrates request/addr_ok handshakes, holds a grant while a request is pending, and records the owner of every accepted transaction so in-order `data_ok`/`rdata` responses go back to the right stage. It sits between the pipeline stages and the memory bridge.

## Interface
- `MAX_OUTSTANDING`, 4: owner-FIFO depth, i.e. the maximum number of accepted transactions still waiting for `data_ok`. Power of two, ≥2.
- `clk`  in  1  clock.
- `resetn`  in  1  synchronous, active-low reset.
- `inst_sram_req/wr/size/addr/wstrb/wdata`  in  1/1/2/32/4/32  master-0 request fields.
- `inst_sram_addr_ok/data_ok`  out  1/1  master-0 handshakes.
- `inst_sram_rdata`  out  32  master-0 read data.
- `data_sram_req/wr/size/addr/wstrb/wdata`  in  1/1/2/32/4/32  master-1 request fields.
- `data_sram_addr_ok/data_ok`  out  1/1  master-1 handshakes.
- `data_sram_rdata`  out  32  master-1 read data.
- `sram_req/wr/size/addr/wstrb/wdata`  out  1/1/2/32/4/32  request to the shared slave.
- `sram_addr_ok/data_ok`  in  1/1  slave handshakes.
- `sram_rdata`  in  32  slave read data.

## Operation
- Grant selection. `lock_valid` is clear and the FIFO is not full: winner is data if `data_sram_req`, else inst if `inst_sram_req`, else none. `lock_valid` is set: winner is `lock_owner`, regardless of the other request.
- Request path (combinational). `sram_req` = winner exists & FIFO not full & `resetn`. `sram_wr/size/addr/wstrb/wdata` are muxed from the winner; they are 0 when there is no winner.
- addr_ok routing. Only the winner sees `sram_addr_ok`; the other master's `addr_ok` is 0.
- Lock behaviour.
  - `sram_req & ~sram_addr_ok` → next cycle `lock_valid`=1 and `lock_owner`=winner.
  - `sram_req & sram_addr_ok` → `lock_valid`=0.
  - Masters hold `req` and the request fields until `addr_ok`. The lock stops the grant switching masters under a pending slave request.
- Owner FIFO.
  - Push the owner bit on `sram_req & sram_addr_ok`. Pop on `sram_data_ok`.
  - `count` is `$clog2(MAX_OUTSTANDING)+1` bits wide.
  - Push and pop in the same cycle leave `count` unchanged; the head advances and the tail writes.
- Response path (combinational). When `sram_data_ok` & FIFO not empty: raise `data_ok` on the head owner's port and drive `sram_rdata` to both `rdata` outputs. Non-owner `data_ok` is 0.
- Boundaries.
  - Full (`count`==`MAX_OUTSTANDING`): `sram_req`=0 and neither master gets `addr_ok`, even if a pop occurs that cycle. There is no bypass. An existing lock stays set.
  - Empty with `sram_data_ok`: protocol error. Both `data_ok` outputs are 0 and `count` stays at 0.
  - Pointers wrap modulo `MAX_OUTSTANDING`.
  - The slave never returns `data_ok` in the same cycle as the matching `addr_ok`, so the FIFO head is always registered before its response.
- Reset. `resetn`=0 clears `lock_valid`, `lock_owner`, the pointers, `count` and the RR state. Outstanding transactions are dropped: responses arriving after reset hit the empty case.

## Timing
- The request path and the addr_ok return have zero added cycles (combinational pass-through). A request accepted in cycle N is visible in the FIFO from cycle N+1.
- Response routing is zero-cycle from `sram_data_ok`.
- Reset values while `resetn`=0 and in the first cycle after reset:
  - `sram_req`=0.
  - All `addr_ok`/`data_ok` = 0.
  - `rdata` = `sram_rdata`, which is don't-care.
- Steady-state throughput is one accepted request per cycle and one response per cycle.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin arbitration.
  - A `last_owner` register updates on every accepted request.
  - When both masters request and there is no lock, the grant goes to the master that is not `last_owner`.
  - `last_owner` resets to inst, so data wins the first tie.
- `SRAM_ARB_RR_EN` undefined: fixed priority, data over inst, with no `last_owner` register.

## Structure
- Shared package `sram_arb_pkg`:
  - `OWNER_INST`=1'b0 and `OWNER_DATA`=1'b1.
  - SRAM-like field widths: addr 32, data 32, wstrb 4, size 2.
- Sub-module `owner_fifo`: synchronous 1-bit-wide FIFO with `push`, `pop`, `full`, `empty`, `head`, parameterised by depth. The arbiter keeps the grant/lock logic and the muxing.

## Test plan
- Single inst read at addr 0x1C000000, slave `addr_ok` the same cycle and `data_ok` 2 cycles later with rdata 0x02800C0C → `inst_sram_addr_ok` pulses once, `inst_sram_data_ok` pulses with `inst_sram_rdata`=0x02800C0C, `data_sram_data_ok` stays 0.
- Inst and data requesting together for 4 cycles, slave always ready:
  - Fixed priority: data accepted 4 times and inst 0 times.
  - With `SRAM_ARB_RR_EN`: order data, inst, data, inst.
- Inst request while the slave holds `addr_ok`=0 for 3 cycles, data request raised in cycle 1 → the slave sees inst fields (lock held) until acceptance; data is granted the next cycle.
- 4 requests accepted with no `data_ok` (`MAX_OUTSTANDING`=4) → 5th request: `sram_req`=0, no `addr_ok`. After one `data_ok`, the 5th request is accepted the next cycle and the responses return in order.
- Owners inst, data, inst outstanding, then 3 `data_ok` pulses with rdata 0x11, 0x22, 0x33 → inst receives 0x11 and 0x33, data receives 0x22. A same-cycle push and pop keeps `count`=3.
- `resetn` low for 1 cycle with 2 transactions outstanding → `count`=0 and the lock is cleared. A stray `sram_data_ok` afterwards produces no master `data_ok`.
